// File: rtl/ddio_bidir_burst_seq.sv
// Fabric-side burst sequencer for one DDIO bidirectional pin group (write/read bursts, turnaround).
// Define DDIO_BIDIR_BURST_SEQ_POSTAMBLE_EN to keep oe high for one postamble cycle after the last write beat.
module ddio_bidir_burst_seq #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic               outclk,
    input  logic               areset,
    input  logic               cmd_valid,
    input  logic               cmd_write,
    output logic               cmd_ready,
    input  logic [2*WIDTH-1:0] wr_data,
    output logic               wr_ack,
    output logic [WIDTH-1:0]   datain_h,
    output logic [WIDTH-1:0]   datain_l,
    output logic               oe,
    input  logic [WIDTH-1:0]   dataout_h,
    input  logic [WIDTH-1:0]   dataout_l,
    output logic               rd_issue,
    output logic [2*WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy
);

    // Counter also has to hold TURNAROUND-1, so it is widened if the turnaround is unusually long.
    localparam int unsigned CNT_SPAN = RD_LATENCY + BURST_LEN + 2;
    localparam int unsigned CW = $clog2((CNT_SPAN > TURNAROUND + 1) ? CNT_SPAN : TURNAROUND + 1);

    localparam logic [CW-1:0] WR_LOAD   = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] RD_LOAD   = CW'(RD_LATENCY + BURST_LEN);
    localparam logic [CW-1:0] TURN_LOAD = CW'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);
    localparam logic [CW-1:0] BL_CNT    = CW'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        WR_PRE,
        WR_DATA,
        WR_POST,
        RD,
        TURN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ready_armed;
    logic          capture;

    always_comb begin
        cmd_ready = ready_armed && (state == IDLE);
        busy      = (state != IDLE);
        wr_ack    = (state == WR_PRE) || ((state == WR_DATA) && (cnt != '0));
        // RD counts down from RD_LATENCY+BURST_LEN; beats arrive while cnt is BURST_LEN..1.
        capture   = (state == RD) && (cnt != '0) && (cnt <= BL_CNT);
    end

    always_ff @(posedge outclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_armed <= 1'b0;
            oe          <= 1'b0;
            datain_h    <= '0;
            datain_l    <= '0;
            rd_issue    <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            ready_armed            <= 1'b1;
            rd_issue               <= 1'b0;
            oe                     <= 1'b0;
            {datain_h, datain_l}   <= wr_ack ? wr_data : '0;
            rd_valid               <= capture;
            if (capture) begin
                rd_data <= {dataout_h, dataout_l};
            end

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_write) begin
                            state <= WR_PRE;
                            oe    <= 1'b1;
                        end else begin
                            state    <= RD;
                            cnt      <= RD_LOAD;
                            rd_issue <= 1'b1;
                        end
                    end
                end
                WR_PRE: begin
                    state <= WR_DATA;
                    cnt   <= WR_LOAD;
                    oe    <= 1'b1;
                end
                WR_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        oe  <= 1'b1;
                    end else begin
`ifdef DDIO_BIDIR_BURST_SEQ_POSTAMBLE_EN
                        state <= WR_POST;
                        oe    <= 1'b1;
`else
                        state <= (TURNAROUND == 0) ? IDLE : TURN;
                        cnt   <= TURN_LOAD;
`endif
                    end
                end
                WR_POST: begin
                    state <= (TURNAROUND == 0) ? IDLE : TURN;
                    cnt   <= TURN_LOAD;
                end
                RD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= (TURNAROUND == 0) ? IDLE : TURN;
                        cnt   <= TURN_LOAD;
                    end
                end
                TURN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddio_bidir_burst_seq.sv
// Scoreboard bench for ddio_bidir_burst_seq: cycle-numbered expectations derived from burst timing rules.
// Honours DDIO_BIDIR_BURST_SEQ_POSTAMBLE_EN the same way as the design build.
module tb_ddio_bidir_burst_seq;

    localparam int unsigned W  = 8;
    localparam int unsigned BL = 4;
    localparam int unsigned RL = 3;
    localparam int unsigned TA = 1;
    localparam int unsigned SB = 1;
    localparam int unsigned SL = 1;
    localparam int unsigned ST = 0;
`ifdef DDIO_BIDIR_BURST_SEQ_POSTAMBLE_EN
    localparam int unsigned POST = 1;
`else
    localparam int unsigned POST = 0;
`endif
    localparam int WR_OCC = BL + 2 + POST + TA;
    localparam int RD_OCC = RL + BL + 2 + TA;

    logic           outclk = 1'b0;
    logic           areset = 1'b1;
    logic           cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [2*W-1:0] wr_data = '0;
    logic [W-1:0]   dataout_h = '0, dataout_l = '0;
    logic           cmd_ready, wr_ack, oe, rd_issue, rd_valid, busy;
    logic [W-1:0]   datain_h, datain_l;
    logic [2*W-1:0] rd_data;

    logic           cmd_valid_s = 1'b0, cmd_write_s = 1'b0;
    logic [2*W-1:0] wr_data_s = '0;
    logic [W-1:0]   dataout_h_s = '0, dataout_l_s = '0;
    logic           cmd_ready_s, wr_ack_s, oe_s, rd_issue_s, rd_valid_s, busy_s;
    logic [W-1:0]   datain_h_s, datain_l_s;
    logic [2*W-1:0] rd_data_s;

    ddio_bidir_burst_seq #(.WIDTH(W), .BURST_LEN(BL), .RD_LATENCY(RL), .TURNAROUND(TA)) dut (
        .outclk(outclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_write(cmd_write),
        .cmd_ready(cmd_ready), .wr_data(wr_data), .wr_ack(wr_ack), .datain_h(datain_h),
        .datain_l(datain_l), .oe(oe), .dataout_h(dataout_h), .dataout_l(dataout_l),
        .rd_issue(rd_issue), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    ddio_bidir_burst_seq #(.WIDTH(W), .BURST_LEN(SB), .RD_LATENCY(SL), .TURNAROUND(ST)) dut_s (
        .outclk(outclk), .areset(areset), .cmd_valid(cmd_valid_s), .cmd_write(cmd_write_s),
        .cmd_ready(cmd_ready_s), .wr_data(wr_data_s), .wr_ack(wr_ack_s), .datain_h(datain_h_s),
        .datain_l(datain_l_s), .oe(oe_s), .dataout_h(dataout_h_s), .dataout_l(dataout_l_s),
        .rd_issue(rd_issue_s), .rd_data(rd_data_s), .rd_valid(rd_valid_s), .busy(busy_s)
    );

    always #5 outclk = ~outclk;

    int cyc = 0;
    always @(posedge outclk) cyc <= cyc + 1;

    typedef struct {
        int             c;
        logic [2*W-1:0] d;
    } ev_t;
    typedef struct {
        int a;
        bit wr;
    } win_t;

    ev_t  q_oe[$];
    ev_t  q_rd[$];
    win_t wins[$];
    int   free_at    = 0;
    int   ready_from = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input int c, input logic [2*W-1:0] d);
        ev_t e;
        e.c = c;
        e.d = d;
        return e;
    endfunction

    function automatic int occ(input bit wr);
        return wr ? WR_OCC : RD_OCC;
    endfunction

    // Reference model: accept rule plus the pin/return schedule of the active burst.
    task automatic model_step(input int c);
        win_t w;
        int   k;
        if (cmd_valid && c >= free_at) begin
            w.a = c;
            w.wr = cmd_write;
            wins.push_back(w);
            free_at = c + occ(cmd_write);
        end
        if (wins.size() > 0) begin
            w = wins[$];
            k = c - w.a;
            if (w.wr) begin
                if (k == 0) q_oe.push_back(mk_ev(c + 1, '0));
                if (k >= 1 && k <= BL) q_oe.push_back(mk_ev(c + 1, wr_data));
                if (POST == 1 && k == BL) q_oe.push_back(mk_ev(c + 2, '0));
            end else if (k >= RL + 1 && k <= RL + BL) begin
                q_rd.push_back(mk_ev(c + 1, {dataout_h, dataout_l}));
            end
        end
    endtask

    task automatic drive(input bit v, input bit w, input logic [2*W-1:0] wd,
                         input logic [W-1:0] dh, input logic [W-1:0] dl);
        @(posedge outclk);
        #1;
        cmd_valid = v;
        cmd_write = w;
        wr_data   = wd;
        dataout_h = dh;
        dataout_l = dl;
        model_step(cyc);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_model_idle();
        for (int i = 0; i < 64 && cyc + 1 < free_at; i++) idle_cycles(1);
    endtask

    // Monitor: control outputs by burst arithmetic, data by popping the scoreboards.
    always @(negedge outclk) begin
        int  c, k;
        bit  inwin;
        ev_t e;
        c = cyc;
        if (areset) begin
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_oe", oe, 0);
            check("rst_datain", {datain_h, datain_l}, 0);
            check("rst_wr_ack", wr_ack, 0);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_issue", rd_issue, 0);
            check("rst_rd_data", rd_data, 0);
        end else begin
            while (wins.size() > 0 && c > wins[0].a + occ(wins[0].wr) - 1) void'(wins.pop_front());
            inwin = (wins.size() > 0) && (c > wins[0].a);
            k = inwin ? c - wins[0].a : 0;
            check("busy", busy, inwin);
            check("cmd_ready", cmd_ready, !inwin && c >= ready_from);
            check("wr_ack", wr_ack, inwin && wins[0].wr && k >= 1 && k <= BL);
            check("rd_issue", rd_issue, inwin && !wins[0].wr && k == 1);
            if (oe) begin
                if (q_oe.size() == 0) check("oe_unexpected", oe, 0);
                else begin
                    e = q_oe.pop_front();
                    check("oe_cycle", c, e.c);
                    check("datain", {datain_h, datain_l}, e.d);
                end
            end else begin
                check("datain_idle", {datain_h, datain_l}, 0);
                if (q_oe.size() > 0 && q_oe[0].c <= c) begin
                    check("oe_missing", oe, 1);
                    void'(q_oe.pop_front());
                end
            end
            if (rd_valid) begin
                if (q_rd.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
                else begin
                    e = q_rd.pop_front();
                    check("rd_cycle", c, e.c);
                    check("rd_data", rd_data, e.d);
                end
            end else if (q_rd.size() > 0 && q_rd[0].c <= c) begin
                check("rd_valid_missing", rd_valid, 1);
                void'(q_rd.pop_front());
            end
        end
    end

    task automatic release_reset();
        @(posedge outclk);
        #1;
        areset     = 1'b0;
        ready_from = cyc + 1;
        free_at    = cyc + 1;
    endtask

    task automatic small_checks(input int k, input bit wr, input logic [2*W-1:0] wd,
                                input logic [2*W-1:0] prev_cap);
        int o;
        o = wr ? int'(SB + 2 + POST + ST) : int'(SL + SB + 2 + ST);
        check("s_cmd_ready", cmd_ready_s, k >= o);
        check("s_busy", busy_s, k < o);
        if (wr) begin
            check("s_oe", oe_s, k >= 1 && k <= int'(SB + 1 + POST));
            check("s_wr_ack", wr_ack_s, k >= 1 && k <= int'(SB));
            check("s_datain", {datain_h_s, datain_l_s}, (k == int'(SB + 1)) ? wd : '0);
        end else begin
            check("s_oe_rd", oe_s, 0);
            check("s_rd_issue", rd_issue_s, k == 1);
            check("s_rd_valid", rd_valid_s, k >= int'(SL + 2) && k <= int'(SL + SB + 1));
            if (rd_valid_s) check("s_rd_data", rd_data_s, prev_cap);
        end
    endtask

    initial begin
        logic [2*W-1:0] beats[4];
        logic [2*W-1:0] hist;
        logic [2*W-1:0] wd_s;
        beats[0] = 16'hA1B2; beats[1] = 16'hC3D4; beats[2] = 16'hE5F6; beats[3] = 16'h0718;

        repeat (3) @(posedge outclk);
        release_reset();

        // Directed write burst
        idle_cycles(1);
        drive(1'b1, 1'b1, 16'h0000, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, beats[i], 8'h00, 8'h00);
        wait_model_idle();
        idle_cycles(2);

        // Directed read burst: beats on dataout in cycles 4..7
        drive(1'b1, 1'b0, '0, 8'h00, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            if (k >= 4 && k <= 7) drive(1'b0, 1'b0, '0, 8'(8'h11 + 8'h22 * (k - 4)), 8'(8'h22 + 8'h22 * (k - 4)));
            else drive(1'b0, 1'b0, '0, 8'h00, 8'h00);
        end
        idle_cycles(2);

        // Write then read with cmd_valid held high throughout
        drive(1'b1, 1'b1, 16'($urandom), 8'($urandom), 8'($urandom));
        for (int k = 1; k < WR_OCC + RD_OCC + 2; k++)
            drive(1'b1, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom));
        drive(1'b0, 1'b0, '0, 8'h00, 8'h00);
        wait_model_idle();
        idle_cycles(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 2) == 0, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
        drive(1'b0, 1'b0, '0, 8'h00, 8'h00);
        wait_model_idle();
        idle_cycles(2);

        // Asynchronous reset in cycle 3 of a write burst
        drive(1'b1, 1'b1, '0, 8'h00, 8'h00);
        for (int k = 1; k <= 3; k++) drive(1'b0, 1'b0, beats[k-1], 8'h00, 8'h00);
        #1 areset = 1'b1;
        #1;
        check("async_oe", oe, 0);
        check("async_datain", {datain_h, datain_l}, 0);
        check("async_wr_ack", wr_ack, 0);
        check("async_busy", busy, 0);
        q_oe.delete();
        q_rd.delete();
        wins.delete();
        repeat (2) @(posedge outclk);
        release_reset();
        drive(1'b1, 1'b0, '0, 8'h00, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            if (k >= 4 && k <= 7) drive(1'b0, 1'b0, '0, 8'(8'h11 + 8'h22 * (k - 4)), 8'(8'h22 + 8'h22 * (k - 4)));
            else drive(1'b0, 1'b0, '0, 8'h00, 8'h00);
        end
        idle_cycles(3);

        // Short configuration: BURST_LEN=1, RD_LATENCY=1, TURNAROUND=0 (read then write)
        @(posedge outclk);
        #1;
        check("s_cmd_ready_idle", cmd_ready_s, 1);
        cmd_valid_s = 1'b1;
        cmd_write_s = 1'b0;
        hist = '0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge outclk);
            #1;
            cmd_valid_s = 1'b0;
            small_checks(k, 1'b0, '0, hist);
            dataout_h_s = 8'($urandom);
            dataout_l_s = 8'($urandom);
            hist = {dataout_h_s, dataout_l_s};
        end
        cmd_valid_s = 1'b1;
        cmd_write_s = 1'b1;
        wd_s = 16'($urandom);
        for (int k = 1; k <= 6; k++) begin
            @(posedge outclk);
            #1;
            cmd_valid_s = 1'b0;
            small_checks(k, 1'b1, wd_s, '0);
            wr_data_s = (k == 1) ? wd_s : 16'($urandom);
        end

        idle_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
